// File: rtl/qspi_pkg.sv
// qspi_pkg: shared state encoding and constants for the QSPI flash responder
package qspi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  localparam logic [7:0] CMD_READ_DEF = 8'hEB;
  localparam logic [7:0] MODE_CONT = 8'hA0;
  localparam int CNT_W = 5;
endpackage

// File: rtl/qspi_sck_edge.sv
// qspi_sck_edge: samples SCK/CS into clk domain and flags SCK edges
// i_sck, i_cs_n: raw link inputs; o_rise/o_fall: one-clk SCK edge strobes; o_cs: sampled CS active
module qspi_sck_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sck,
  input  logic i_cs_n,
  output logic o_rise,
  output logic o_fall,
  output logic o_cs
);
  logic r_sck, r_sck_d, r_cs_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sck <= 1'b0;
      r_sck_d <= 1'b0;
      r_cs_n <= 1'b1;
    end else begin
      r_sck <= i_sck;
      r_sck_d <= r_sck;
      r_cs_n <= i_cs_n;
    end
  assign o_rise = r_sck & ~r_sck_d;
  assign o_fall = ~r_sck & r_sck_d;
  assign o_cs = ~r_cs_n;
endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: QSPI Fast Read Quad I/O (0xEB) target serving nibbles from a synchronous ROM
// spi_sck/spi_cs_n/spi_io_in: initiator link; spi_io_out/spi_io_oe: driven IO lines
// mem_addr/mem_rdata: ROM port (data one clk after address); cmd_error: sticky bad-opcode flag
// QSPI_CONT_READ_EN: mode byte 8'hA0 arms continuous read (next transaction skips the opcode)
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DUMMY_CYCLES = 6,
  parameter logic [7:0] CMD_READ = CMD_READ_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic [3:0]        spi_io_in,
  output logic [3:0]        spi_io_out,
  output logic [3:0]        spi_io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              cmd_error
);
  logic w_rise, w_fall, w_cs, w_last, w_dfall, w_issue, w_arm;
  logic [7:0] w_op;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [19:0] r_sh;
  logic [7:0] r_tx;
  logic [1:0] r_ld;
  logic r_nib;
  qspi_sck_edge u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .i_sck (spi_sck),
    .i_cs_n(spi_cs_n),
    .o_rise(w_rise),
    .o_fall(w_fall),
    .o_cs  (w_cs)
  );
  assign w_op = {r_sh[6:0], spi_io_in[0]};
  assign w_last = w_rise & w_cs & (r_state == CMD ? r_cnt == CNT_W'(7) :
                                   r_state == ADDR ? r_cnt == CNT_W'(5) :
                                   r_state == DUMMY ? r_cnt == CNT_W'(DUMMY_CYCLES - 1) : 1'b0);
  assign w_dfall = w_fall & w_cs & (r_state == DATA);
  // ROM read is issued once at the end of the address and after each low nibble
  assign w_issue = (w_last & (r_state == ADDR)) | (w_dfall & r_nib);
`ifdef QSPI_CONT_READ_EN
  logic [3:0] r_mode_hi;
  logic r_arm;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mode_hi <= 4'h0;
      r_arm <= 1'b0;
    end else if (w_rise && w_cs && r_state == DUMMY) begin
      if (r_cnt == CNT_W'(0)) r_mode_hi <= spi_io_in;
      if (r_cnt == CNT_W'(1)) r_arm <= {r_mode_hi, spi_io_in} == MODE_CONT;
    end
  assign w_arm = r_arm;
`else
  assign w_arm = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (!w_cs) w_next = IDLE;
    else
      case (r_state)
        IDLE:    w_next = w_arm ? ADDR : CMD;
        CMD:     w_next = w_last ? (w_op == CMD_READ ? ADDR : IGNORE) : CMD;
        ADDR:    w_next = w_last ? DUMMY : ADDR;
        DUMMY:   w_next = w_last ? DATA : DUMMY;
        default: w_next = r_state;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_sh <= '0;
      r_tx <= '0;
      r_ld <= '0;
      r_nib <= 1'b0;
      mem_addr <= '0;
      spi_io_out <= 4'h0;
      spi_io_oe <= 4'h0;
      cmd_error <= 1'b0;
    end else begin
      r_ld <= {r_ld[0], w_issue};
      if (r_ld[1]) r_tx <= mem_rdata;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_rise) r_cnt <= r_cnt + 1'b1;
      if (w_rise && r_state == CMD) r_sh <= {r_sh[18:0], spi_io_in[0]};
      if (w_rise && r_state == ADDR) r_sh <= {r_sh[15:0], spi_io_in};
      if (w_last && r_state == CMD && w_op != CMD_READ) cmd_error <= 1'b1;
      if (w_issue) mem_addr <= r_state == ADDR ? ADDR_W'({r_sh, spi_io_in}) : mem_addr + 1'b1;
      if (w_dfall) begin
        spi_io_out <= r_nib ? r_tx[3:0] : r_tx[7:4];
        spi_io_oe <= 4'hF;
        r_nib <= ~r_nib;
      end else if (w_next != DATA) begin
        spi_io_out <= 4'h0;
        spi_io_oe <= 4'h0;
        r_nib <= 1'b0;
      end
    end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder: directed self-checking bench for the QSPI flash responder
`timescale 1ns/1ps
module tb_qspi_flash_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sck = 1'b0;
  logic spi_cs_n = 1'b1;
  logic [3:0] spi_io_in = 4'h0;
  logic [3:0] spi_io_out, spi_io_oe;
  logic [15:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic cmd_error;
  int checks = 0;
  int errors = 0;
  qspi_flash_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_io_in (spi_io_in),
    .spi_io_out(spi_io_out),
    .spi_io_oe (spi_io_oe),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cmd_error (cmd_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic sck_bit(input logic [3:0] d, output logic [3:0] n, output logic [3:0] oe);
    spi_io_in = d;
    repeat (4) @(negedge clk);
    n = spi_io_out;
    oe = spi_io_oe;
    spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b0;
  endtask
  task automatic start();
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic stop();
    @(negedge clk) spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic send_hdr(input logic with_cmd, input logic [7:0] op, input logic [23:0] a,
                          input logic [7:0] mode, output logic [3:0] acc);
    logic [3:0] n, oe;
    acc = 4'h0;
    if (with_cmd)
      for (int i = 7; i >= 0; i--) begin
        sck_bit({3'b000, op[i]}, n, oe);
        acc |= oe;
      end
    for (int i = 5; i >= 0; i--) begin
      sck_bit(a[i*4 +: 4], n, oe);
      acc |= oe;
    end
    for (int i = 0; i < 6; i++) begin
      sck_bit(i == 0 ? mode[7:4] : i == 1 ? mode[3:0] : 4'h0, n, oe);
      acc |= oe;
    end
  endtask
  task automatic read_byte(output logic [7:0] b, output logic [3:0] oe);
    logic [3:0] h, l, o1, o2;
    sck_bit(4'h0, h, o1);
    sck_bit(4'h0, l, o2);
    b = {h, l};
    oe = o1 & o2;
  endtask
  task automatic test_reset();
    checks++; if (spi_io_out !== 4'h0) begin errors++; $display("FAIL reset_io got %h want 0", spi_io_out); end
    checks++; if (spi_io_oe !== 4'h0) begin errors++; $display("FAIL reset_oe got %h want 0", spi_io_oe); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", cmd_error); end
  endtask
  task automatic test_read();
    logic [3:0] acc, oe;
    logic [7:0] b;
    logic [7:0] exp [4];
    exp = '{8'h4A, 8'h4B, 8'h48, 8'h49};
    start();
    send_hdr(1'b1, 8'hEB, 24'h000010, 8'h00, acc);
    checks++; if (acc !== 4'h0) begin errors++; $display("FAIL read_hdr_oe got %h want 0", acc); end
    for (int i = 0; i < 4; i++) begin
      read_byte(b, oe);
      checks++; if (b !== exp[i]) begin errors++; $display("FAIL read_byte%0d got %h want %h", i, b, exp[i]); end
      checks++; if (oe !== 4'hF) begin errors++; $display("FAIL read_oe%0d got %h want f", i, oe); end
    end
    stop();
    checks++; if (spi_io_oe !== 4'h0) begin errors++; $display("FAIL read_idle_oe got %h want 0", spi_io_oe); end
  endtask
  task automatic test_bad_opcode();
    logic [3:0] acc, oe;
    logic [7:0] b;
    start();
    send_hdr(1'b1, 8'h03, 24'h000010, 8'h00, acc);
    for (int i = 0; i < 4; i++) begin
      read_byte(b, oe);
      acc |= oe;
    end
    checks++; if (acc !== 4'h0) begin errors++; $display("FAIL bad_oe got %h want 0", acc); end
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL bad_err got %b want 1", cmd_error); end
    stop();
    start();
    send_hdr(1'b1, 8'hEB, 24'h000010, 8'h00, acc);
    read_byte(b, oe);
    checks++; if (b !== 8'h4A) begin errors++; $display("FAIL bad_next got %h want 4a", b); end
    stop();
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b want 1", cmd_error); end
  endtask
  task automatic test_wrap();
    logic [3:0] acc, oe;
    logic [7:0] b;
    start();
    send_hdr(1'b1, 8'hEB, 24'h00FFFF, 8'h00, acc);
    read_byte(b, oe);
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL wrap_ffff got %h want a5", b); end
    read_byte(b, oe);
    checks++; if (b !== 8'h5A) begin errors++; $display("FAIL wrap_0000 got %h want 5a", b); end
    stop();
  endtask
  task automatic test_cs_abort();
    logic [3:0] acc, oe, n;
    logic [7:0] b;
    start();
    send_hdr(1'b1, 8'hEB, 24'h000010, 8'h00, acc);
    read_byte(b, oe);
    sck_bit(4'h0, n, oe);
    checks++; if ({n, oe} !== 8'h4F) begin errors++; $display("FAIL abort_nib got %h want 4f", {n, oe}); end
    @(negedge clk) spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (spi_io_oe !== 4'h0) begin errors++; $display("FAIL abort_oe got %h want 0", spi_io_oe); end
    repeat (2) @(negedge clk);
    start();
    send_hdr(1'b1, 8'hEB, 24'h000020, 8'h00, acc);
    read_byte(b, oe);
    checks++; if (b !== 8'h7A) begin errors++; $display("FAIL abort_next got %h want 7a", b); end
    stop();
  endtask
  task automatic test_reset_mid();
    logic [3:0] acc, oe;
    logic [7:0] b;
    start();
    send_hdr(1'b1, 8'hEB, 24'h000010, 8'h00, acc);
    read_byte(b, oe);
    repeat (3) @(negedge clk);
    checks++; if (spi_io_oe !== 4'hF) begin errors++; $display("FAIL rstmid_pre got %h want f", spi_io_oe); end
    rst_n = 1'b0;
    #1;
    checks++; if (spi_io_oe !== 4'h0) begin errors++; $display("FAIL rstmid_oe got %h want 0", spi_io_oe); end
    checks++; if (spi_io_out !== 4'h0) begin errors++; $display("FAIL rstmid_io got %h want 0", spi_io_out); end
    spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start();
    send_hdr(1'b1, 8'hEB, 24'h000001, 8'h00, acc);
    read_byte(b, oe);
    checks++; if (b !== 8'h5B) begin errors++; $display("FAIL rstmid_next got %h want 5b", b); end
    stop();
  endtask
`ifdef QSPI_CONT_READ_EN
  task automatic test_cont();
    logic [3:0] acc, oe;
    logic [7:0] b;
    start();
    send_hdr(1'b1, 8'hEB, 24'h000010, 8'hA0, acc);
    read_byte(b, oe);
    stop();
    start();
    send_hdr(1'b0, 8'h00, 24'h000003, 8'h00, acc);
    read_byte(b, oe);
    checks++; if (b !== 8'h59) begin errors++; $display("FAIL cont_addr got %h want 59", b); end
    stop();
    start();
    send_hdr(1'b1, 8'hEB, 24'h000003, 8'h00, acc);
    read_byte(b, oe);
    checks++; if (b !== 8'h59) begin errors++; $display("FAIL cont_disarm got %h want 59", b); end
    stop();
  endtask
`endif
  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_read();
    test_wrap();
    test_cs_abort();
`ifdef QSPI_CONT_READ_EN
    test_cont();
`endif
    test_bad_opcode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
